// File: rtl/nv_nvdla_pdp_core_med1d_lut_ctrl_pkg.sv
// Shared constants and FSM state encodings for the PDP med1d LUT controller.
package nv_nvdla_pdp_core_med1d_lut_ctrl_pkg;
  localparam int MED1D_LUT_DEPTH = 120;
  localparam int MED1D_IDX_W = 7;
  localparam int MED1D_MSB_W = 3;
  localparam int MED1D_LANES = 4;

  typedef enum logic [1:0] {
    E_IDLE,
    E_LOOK,
    E_RESP
  } enc_state_e;

  typedef enum logic [1:0] {
    D_IDLE,
    D_LOOK,
    D_RESP
  } dec_state_e;
endpackage

// File: rtl/nv_nvdla_pdp_core_med1d_rr_arb.sv
// Round-robin arbiter; the pointer moves past the winner on each grant.
module nv_nvdla_pdp_core_med1d_rr_arb #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req_i,
  input  logic            en_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [ID_W-1:0] gnt_id_o,
  output logic            any_o
);
  localparam logic [ID_W:0] N_L = (ID_W+1)'(NREQ);

  logic [ID_W-1:0] ptr_q;
  logic [ID_W:0]   cand;

  always_comb begin
    cand = '0;
    any_o = 1'b0;
    gnt_id_o = '0;
    gnt_o = '0;
    for (int off = 0; off < NREQ; off++) begin
      cand = {1'b0, ptr_q} + (ID_W+1)'(off);
      if (cand >= N_L) cand = cand - N_L;
      if (!any_o && req_i[cand[ID_W-1:0]]) begin
        any_o = 1'b1;
        gnt_id_o = cand[ID_W-1:0];
      end
    end
    if (en_i && any_o) gnt_o[gnt_id_o] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (en_i && any_o) begin
      ptr_q <= (gnt_id_o == ID_W'(NREQ-1)) ? '0 : gnt_id_o + ID_W'(1);
    end
  end
endmodule

// File: rtl/nv_nvdla_pdp_core_med1d_lut_ctrl.sv
// Encode arbiter/sequencer and decode sequencer in front of the med1d MSB LUT.
module nv_nvdla_pdp_core_med1d_lut_ctrl
  import nv_nvdla_pdp_core_med1d_lut_ctrl_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic                   nvdla_core_clk,
  input  logic                   nvdla_core_rst,
  input  logic [NREQ-1:0]        enc_req_valid,
  output logic [NREQ-1:0]        enc_req_ready,
  input  logic [NREQ*9-1:0]      enc_req_msbs,
  output logic                   enc_rsp_valid,
  input  logic                   enc_rsp_ready,
  output logic [MED1D_IDX_W-1:0] enc_rsp_idx,
  output logic [ID_W-1:0]        enc_rsp_id,
  input  logic                   dec_req_valid,
  output logic                   dec_req_ready,
  input  logic [27:0]            dec_req_idx,
  output logic                   dec_rsp_valid,
  input  logic                   dec_rsp_ready,
  output logic [11:0]            dec_rsp_k,
  output logic [11:0]            dec_rsp_j,
  output logic [11:0]            dec_rsp_i,
  output logic [3:0]             dec_rsp_err,
  output logic                   lut_encoding,
  output logic                   lut_decoding,
  output logic [MED1D_MSB_W-1:0] lut_a_msbs,
  output logic [MED1D_MSB_W-1:0] lut_b_msbs,
  output logic [MED1D_MSB_W-1:0] lut_c_msbs,
  input  logic [MED1D_IDX_W-1:0] lut_enc_idx,
  output logic [27:0]            lut_to_decode,
  input  logic [11:0]            lut_dec_k,
  input  logic [11:0]            lut_dec_j,
  input  logic [11:0]            lut_dec_i
);
  enc_state_e      enc_st_q;
  logic [8:0]      enc_ops_q;
  logic [ID_W-1:0] enc_id_q;
  logic [6:0]      enc_idx_q;
  logic            enc_vld_q;
  logic            enc_can;
  logic            enc_any;
  logic [ID_W-1:0] enc_gid;
  logic [8:0]      enc_sel_ops;

  dec_state_e      dec_st_q;
  logic [27:0]     dec_idx_q;
  logic            dec_vld_q;
  logic [11:0]     dec_k_q, dec_j_q, dec_i_q;
  logic [11:0]     dec_k_d, dec_j_d, dec_i_d;
  logic [3:0]      dec_err_q;
  logic [3:0]      dec_bad;
  logic            dec_can;

  assign enc_can = (enc_st_q == E_IDLE) ||
                   ((enc_st_q == E_RESP) && enc_rsp_ready);

  nv_nvdla_pdp_core_med1d_rr_arb #(
    .NREQ(NREQ),
    .ID_W(ID_W)
  ) u_arb (
    .clk     (nvdla_core_clk),
    .rst     (nvdla_core_rst),
    .req_i   (enc_req_valid),
    .en_i    (enc_can),
    .gnt_o   (enc_req_ready),
    .gnt_id_o(enc_gid),
    .any_o   (enc_any)
  );

  assign enc_sel_ops = enc_req_msbs[int'(enc_gid)*9 +: 9];

  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      enc_st_q  <= E_IDLE;
      enc_ops_q <= '0;
      enc_id_q  <= '0;
      enc_idx_q <= '0;
      enc_vld_q <= 1'b0;
    end else begin
      unique case (enc_st_q)
        E_IDLE: if (enc_any) begin
          enc_ops_q <= enc_sel_ops;
          enc_id_q  <= enc_gid;
          enc_st_q  <= E_LOOK;
        end
        E_LOOK: begin
          enc_idx_q <= lut_enc_idx;
          enc_vld_q <= 1'b1;
          enc_st_q  <= E_RESP;
        end
        E_RESP: if (enc_rsp_ready) begin
          enc_vld_q <= 1'b0;
          if (enc_any) begin
            enc_ops_q <= enc_sel_ops;
            enc_id_q  <= enc_gid;
            enc_st_q  <= E_LOOK;
          end else begin
            enc_st_q <= E_IDLE;
          end
        end
        default: enc_st_q <= E_IDLE;
      endcase
    end
  end

  // LUT operands stay at zero outside lookups to keep it from toggling
  assign lut_encoding  = (enc_st_q == E_LOOK);
  assign lut_a_msbs    = lut_encoding ? enc_ops_q[8:6] : '0;
  assign lut_b_msbs    = lut_encoding ? enc_ops_q[5:3] : '0;
  assign lut_c_msbs    = lut_encoding ? enc_ops_q[2:0] : '0;
  assign enc_rsp_valid = enc_vld_q;
  assign enc_rsp_idx   = enc_idx_q;
  assign enc_rsp_id    = enc_id_q;

  assign dec_can = (dec_st_q == D_IDLE) ||
                   ((dec_st_q == D_RESP) && dec_rsp_ready);
  assign dec_req_ready = dec_can && dec_req_valid;
  assign lut_decoding  = (dec_st_q == D_LOOK);

  always_comb begin
    dec_bad = '0;
    lut_to_decode = '0;
    dec_k_d = '0;
    dec_j_d = '0;
    dec_i_d = '0;
    for (int n = 0; n < MED1D_LANES; n++) begin
      dec_bad[n] = dec_idx_q[n*7 +: 7] >= 7'(MED1D_LUT_DEPTH);
      if (lut_decoding && !dec_bad[n]) begin
        lut_to_decode[n*7 +: 7] = dec_idx_q[n*7 +: 7];
      end
      if (!dec_bad[n]) begin
        dec_k_d[n*3 +: 3] = lut_dec_k[n*3 +: 3];
        dec_j_d[n*3 +: 3] = lut_dec_j[n*3 +: 3];
        dec_i_d[n*3 +: 3] = lut_dec_i[n*3 +: 3];
      end
    end
  end

  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      dec_st_q  <= D_IDLE;
      dec_idx_q <= '0;
      dec_vld_q <= 1'b0;
      dec_k_q   <= '0;
      dec_j_q   <= '0;
      dec_i_q   <= '0;
      dec_err_q <= '0;
    end else begin
      unique case (dec_st_q)
        D_IDLE: if (dec_req_valid) begin
          dec_idx_q <= dec_req_idx;
          dec_st_q  <= D_LOOK;
        end
        D_LOOK: begin
          dec_k_q   <= dec_k_d;
          dec_j_q   <= dec_j_d;
          dec_i_q   <= dec_i_d;
          dec_err_q <= dec_bad;
          dec_vld_q <= 1'b1;
          dec_st_q  <= D_RESP;
        end
        D_RESP: if (dec_rsp_ready) begin
          dec_vld_q <= 1'b0;
          if (dec_req_valid) begin
            dec_idx_q <= dec_req_idx;
            dec_st_q  <= D_LOOK;
          end else begin
            dec_st_q <= D_IDLE;
          end
        end
        default: dec_st_q <= D_IDLE;
      endcase
    end
  end

  assign dec_rsp_valid = dec_vld_q;
  assign dec_rsp_k     = dec_k_q;
  assign dec_rsp_j     = dec_j_q;
  assign dec_rsp_i     = dec_i_q;
  assign dec_rsp_err   = dec_err_q;
endmodule

// File: tb/tb_nv_nvdla_pdp_core_med1d_lut_ctrl.sv
// Directed bench for the med1d LUT controller with a behavioural LUT attached.
module tb_nv_nvdla_pdp_core_med1d_lut_ctrl;
  logic        clk;
  logic        rst;
  logic [3:0]  enc_req_valid;
  logic [3:0]  enc_req_ready;
  logic [35:0] enc_req_msbs;
  logic        enc_rsp_valid;
  logic        enc_rsp_ready;
  logic [6:0]  enc_rsp_idx;
  logic [1:0]  enc_rsp_id;
  logic        dec_req_valid;
  logic        dec_req_ready;
  logic [27:0] dec_req_idx;
  logic        dec_rsp_valid;
  logic        dec_rsp_ready;
  logic [11:0] dec_rsp_k, dec_rsp_j, dec_rsp_i;
  logic [3:0]  dec_rsp_err;
  logic        lut_encoding, lut_decoding;
  logic [2:0]  lut_a_msbs, lut_b_msbs, lut_c_msbs;
  logic [6:0]  lut_enc_idx;
  logic [27:0] lut_to_decode;
  logic [11:0] lut_dec_k, lut_dec_j, lut_dec_i;

  int errors = 0;
  int checks = 0;

  nv_nvdla_pdp_core_med1d_lut_ctrl #(
    .NREQ(4),
    .ID_W(2)
  ) dut (
    .nvdla_core_clk(clk),
    .nvdla_core_rst(rst),
    .enc_req_valid (enc_req_valid),
    .enc_req_ready (enc_req_ready),
    .enc_req_msbs  (enc_req_msbs),
    .enc_rsp_valid (enc_rsp_valid),
    .enc_rsp_ready (enc_rsp_ready),
    .enc_rsp_idx   (enc_rsp_idx),
    .enc_rsp_id    (enc_rsp_id),
    .dec_req_valid (dec_req_valid),
    .dec_req_ready (dec_req_ready),
    .dec_req_idx   (dec_req_idx),
    .dec_rsp_valid (dec_rsp_valid),
    .dec_rsp_ready (dec_rsp_ready),
    .dec_rsp_k     (dec_rsp_k),
    .dec_rsp_j     (dec_rsp_j),
    .dec_rsp_i     (dec_rsp_i),
    .dec_rsp_err   (dec_rsp_err),
    .lut_encoding  (lut_encoding),
    .lut_decoding  (lut_decoding),
    .lut_a_msbs    (lut_a_msbs),
    .lut_b_msbs    (lut_b_msbs),
    .lut_c_msbs    (lut_c_msbs),
    .lut_enc_idx   (lut_enc_idx),
    .lut_to_decode (lut_to_decode),
    .lut_dec_k     (lut_dec_k),
    .lut_dec_j     (lut_dec_j),
    .lut_dec_i     (lut_dec_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // LUT: sorted multisets k<=j<=i enumerated in lexicographic order
  function automatic logic [6:0] enc_model(input logic [2:0] a,
                                           input logic [2:0] b,
                                           input logic [2:0] c);
    logic [2:0] s0, s1, s2, t;
    int n;
    s0 = a; s1 = b; s2 = c;
    if (s0 > s1) begin t = s0; s0 = s1; s1 = t; end
    if (s1 > s2) begin t = s1; s1 = s2; s2 = t; end
    if (s0 > s1) begin t = s0; s0 = s1; s1 = t; end
    n = 0;
    enc_model = '0;
    for (int k = 0; k < 8; k++)
      for (int j = k; j < 8; j++)
        for (int i = j; i < 8; i++) begin
          if (k == int'(s0) && j == int'(s1) && i == int'(s2))
            enc_model = 7'(n);
          n++;
        end
  endfunction

  function automatic logic [8:0] dec_model(input logic [6:0] idx);
    int n;
    n = 0;
    dec_model = '0;
    for (int k = 0; k < 8; k++)
      for (int j = k; j < 8; j++)
        for (int i = j; i < 8; i++) begin
          if (n == int'(idx)) dec_model = {3'(k), 3'(j), 3'(i)};
          n++;
        end
  endfunction

  always_comb begin
    logic [8:0] r;
    lut_enc_idx = enc_model(lut_a_msbs, lut_b_msbs, lut_c_msbs);
    lut_dec_k = '0;
    lut_dec_j = '0;
    lut_dec_i = '0;
    for (int n = 0; n < 4; n++) begin
      r = dec_model(lut_to_decode[n*7 +: 7]);
      lut_dec_k[n*3 +: 3] = r[8:6];
      lut_dec_j[n*3 +: 3] = r[5:3];
      lut_dec_i[n*3 +: 3] = r[2:0];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic enc_one(input int r, input logic [2:0] a,
                         input logic [2:0] b, input logic [2:0] c,
                         input logic [6:0] exp_idx);
    enc_req_msbs = '0;
    enc_req_msbs[9*r +: 9] = {a, b, c};
    enc_req_valid = 4'(1 << r);
    #1 chk("enc_rdy", 32'(enc_req_ready), 32'(1 << r));
    @(negedge clk);
    enc_req_valid = '0;
    enc_req_msbs = '1;
    #1 chk("enc_look", 32'(lut_encoding), 1);
    chk("enc_ops", 32'({lut_a_msbs, lut_b_msbs, lut_c_msbs}), 32'({a, b, c}));
    chk("enc_vld_early", 32'(enc_rsp_valid), 0);
    @(negedge clk);
    #1 chk("enc_vld", 32'(enc_rsp_valid), 1);
    chk("enc_idx", 32'(enc_rsp_idx), 32'(exp_idx));
    chk("enc_id", 32'(enc_rsp_id), 32'(r));
    enc_rsp_ready = 1'b1;
    @(negedge clk);
    enc_rsp_ready = 1'b0;
    #1 chk("enc_vld_drop", 32'(enc_rsp_valid), 0);
    chk("enc_look_off", 32'({lut_encoding, lut_a_msbs, lut_b_msbs, lut_c_msbs}), 0);
  endtask

  task automatic dec_one(input logic [27:0] req, input logic [27:0] exp_lut,
                         input logic [11:0] ek, input logic [11:0] ej,
                         input logic [11:0] ei, input logic [3:0] eerr);
    dec_req_idx = req;
    dec_req_valid = 1'b1;
    #1 chk("dec_rdy", 32'(dec_req_ready), 1);
    @(negedge clk);
    dec_req_valid = 1'b0;
    dec_req_idx = '1;
    #1 chk("dec_look", 32'(lut_decoding), 1);
    chk("dec_lut_in", 32'(lut_to_decode), 32'(exp_lut));
    chk("dec_vld_early", 32'(dec_rsp_valid), 0);
    @(negedge clk);
    #1 chk("dec_vld", 32'(dec_rsp_valid), 1);
    chk("dec_k", 32'(dec_rsp_k), 32'(ek));
    chk("dec_j", 32'(dec_rsp_j), 32'(ej));
    chk("dec_i", 32'(dec_rsp_i), 32'(ei));
    chk("dec_err", 32'(dec_rsp_err), 32'(eerr));
    dec_rsp_ready = 1'b1;
    @(negedge clk);
    dec_rsp_ready = 1'b0;
    #1 chk("dec_vld_drop", 32'(dec_rsp_valid), 0);
    chk("dec_look_off", 32'({lut_decoding, lut_to_decode}), 0);
  endtask

  initial begin
    rst = 1'b1;
    enc_req_valid = '0;
    enc_req_msbs = '0;
    enc_rsp_ready = 1'b0;
    dec_req_valid = 1'b0;
    dec_req_idx = '0;
    dec_rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1 chk("rst_enc_vld", 32'(enc_rsp_valid), 0);
    chk("rst_enc_rsp", 32'({enc_rsp_idx, enc_rsp_id}), 0);
    chk("rst_rdy", 32'({enc_req_ready, dec_req_ready}), 0);
    chk("rst_dec_vld", 32'(dec_rsp_valid), 0);
    chk("rst_dec_rsp", 32'({dec_rsp_k, dec_rsp_j, dec_rsp_i, dec_rsp_err}), 0);
    chk("rst_lut", 32'({lut_encoding, lut_decoding, lut_a_msbs,
                        lut_b_msbs, lut_c_msbs}), 0);
    chk("rst_lut_dec", 32'(lut_to_decode), 0);
    rst = 1'b0;

    // all four requesters from the reset pointer
    @(negedge clk);
    for (int n = 0; n < 4; n++) enc_req_msbs[9*n +: 9] = {3'(n), 6'd0};
    enc_req_valid = 4'hF;
    enc_rsp_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      #1 chk("rr4_rdy", 32'(enc_req_ready), 32'(1 << n));
      @(negedge clk);
      enc_req_valid[n] = 1'b0;
      #1 chk("rr4_look", 32'({lut_encoding, enc_rsp_valid}), 32'h2);
      @(negedge clk);
      #1 chk("rr4_vld", 32'(enc_rsp_valid), 1);
      chk("rr4_id", 32'(enc_rsp_id), 32'(n));
      chk("rr4_idx", 32'(enc_rsp_idx), 32'(n));
    end
    @(negedge clk);
    enc_rsp_ready = 1'b0;
    #1 chk("rr4_idle", 32'(enc_rsp_valid), 0);

    enc_one(0, 3'd0, 3'd0, 3'd1, 7'd1);
    enc_one(1, 3'd7, 3'd0, 3'd0, 7'd7);
    enc_one(2, 3'd2, 3'd5, 3'd3, 7'd72);
    enc_one(2, 3'd7, 3'd7, 3'd7, 7'd119);

    // pointer now at 3: requesters 1 and 2 together
    enc_req_msbs = '0;
    enc_req_msbs[9 +: 9] = 9'd1;
    enc_req_msbs[18 +: 9] = 9'd2;
    enc_req_valid = 4'b0110;
    enc_rsp_ready = 1'b1;
    #1 chk("rr_first", 32'(enc_req_ready), 32'b0010);
    @(negedge clk);
    enc_req_valid = 4'b0100;
    @(negedge clk);
    #1 chk("rr_id1", 32'({enc_rsp_valid, enc_rsp_id}), 32'b101);
    chk("rr_second", 32'(enc_req_ready), 32'b0100);
    @(negedge clk);
    enc_req_valid = '0;
    @(negedge clk);
    #1 chk("rr_id2", 32'({enc_rsp_valid, enc_rsp_id, enc_rsp_idx}),
           32'({1'b1, 2'd2, 7'd2}));
    @(negedge clk);
    enc_rsp_ready = 1'b0;

    dec_one({7'd119, 7'd0, 7'd72, 7'd64}, {7'd119, 7'd0, 7'd72, 7'd64},
            12'hE12, 12'hE1A, 12'hE2A, 4'b0000);
    dec_one({7'd119, 7'd0, 7'd120, 7'd64}, {7'd119, 7'd0, 7'd0, 7'd64},
            12'hE02, 12'hE02, 12'hE02, 4'b0010);

    // concurrent accept, response stall, then reset during lookup
    @(negedge clk);
    enc_req_msbs = '0;
    enc_req_msbs[27 +: 9] = {3'd7, 3'd0, 3'd0};
    enc_req_valid = 4'b1000;
    dec_req_idx = {7'd119, 7'd0, 7'd72, 7'd64};
    dec_req_valid = 1'b1;
    #1 chk("cc_rdy", 32'({enc_req_ready, dec_req_ready}), 32'b10001);
    @(negedge clk);
    enc_req_msbs[0 +: 9] = {3'd0, 3'd0, 3'd5};
    enc_req_valid = 4'b0001;
    dec_req_valid = 1'b0;
    #1 chk("cc_look", 32'({lut_encoding, lut_decoding, enc_req_ready}),
           32'b110000);
    @(negedge clk);
    for (int s = 0; s < 5; s++) begin
      #1 chk("stall_enc", 32'({enc_rsp_valid, enc_rsp_id, enc_rsp_idx}),
             32'({1'b1, 2'd3, 7'd7}));
      chk("stall_nogrant", 32'(enc_req_ready), 0);
      chk("stall_dec", 32'({dec_rsp_valid, dec_rsp_k}), 32'({1'b1, 12'hE12}));
      @(negedge clk);
    end
    enc_rsp_ready = 1'b1;
    #1 chk("stall_release", 32'(enc_req_ready), 32'b0001);
    @(negedge clk);
    enc_rsp_ready = 1'b0;
    enc_req_valid = '0;
    #1 chk("look2", 32'({lut_encoding, lut_c_msbs}), 32'b1101);
    rst = 1'b1;
    #1 chk("arst_lut", 32'({lut_encoding, lut_decoding, lut_a_msbs,
                             lut_b_msbs, lut_c_msbs}), 0);
    chk("arst_enc", 32'({enc_rsp_valid, enc_rsp_id, enc_rsp_idx}), 0);
    chk("arst_dec", 32'({dec_rsp_valid, dec_rsp_err, dec_rsp_k}), 0);
    @(negedge clk);
    rst = 1'b0;
    enc_rsp_ready = 1'b1;
    dec_rsp_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1 chk("post_rst_quiet", 32'({enc_rsp_valid, dec_rsp_valid}), 0);
    end
    enc_req_valid = 4'hF;
    #1 chk("post_rst_ptr", 32'(enc_req_ready), 32'b0001);
    enc_req_valid = '0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
